// File: rtl/inst_fetch_buffer_if.sv
// Fetch-to-issue bundle for the instruction fetch buffer: push slots from the
// cache read stage, pop control from issue, and the FWFT head pair back out.
interface inst_fetch_buffer_if #(
    parameter int PTR_W = 4
);
    logic             flush;
    logic             inst1_valid_i;
    logic             inst2_valid_i;
    logic [31:0]      inst1_i;
    logic [31:0]      inst2_i;
    logic [31:0]      inst1_addr_i;
    logic [31:0]      inst2_addr_i;
    logic             issue_i;
    logic             issue_mode_i;
    logic [31:0]      inst1_o;
    logic [31:0]      inst1_addr_o;
    logic             inst1_valid_o;
    logic [31:0]      inst2_o;
    logic [31:0]      inst2_addr_o;
    logic             inst2_valid_o;
    logic [PTR_W:0]   count_o;
    logic             full_o;

    modport master (
        output flush, inst1_valid_i, inst2_valid_i, inst1_i, inst2_i,
               inst1_addr_i, inst2_addr_i, issue_i, issue_mode_i,
        input  inst1_o, inst1_addr_o, inst1_valid_o, inst2_o, inst2_addr_o,
               inst2_valid_o, count_o, full_o
    );

    modport slave (
        input  flush, inst1_valid_i, inst2_valid_i, inst1_i, inst2_i,
               inst1_addr_i, inst2_addr_i, issue_i, issue_mode_i,
        output inst1_o, inst1_addr_o, inst1_valid_o, inst2_o, inst2_addr_o,
               inst2_valid_o, count_o, full_o
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Dual-push / dual-pop instruction queue with first-word-fall-through head pair.
// Pointers wrap modulo DEPTH; a push that would overflow is dropped whole.
module inst_fetch_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_fetch_buffer_if.slave   bus
);
    localparam int CNT_W = PTR_W + 1;

    logic [63:0]       mem_reg [DEPTH];
    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  head_plus1, tail_plus1;
    logic [CNT_W-1:0]  pop_req, pop_n, push_n;
    logic [CNT_W:0]    occ_after;
    logic              push_ok;
    logic              we1, we2;
    logic [63:0]       rd1, rd2;

    assign head_plus1 = head_reg + PTR_W'(1);
    assign tail_plus1 = tail_reg + PTR_W'(1);

    always_comb begin
        pop_req = '0;
        if (bus.issue_i) begin
            pop_req = bus.issue_mode_i ? CNT_W'(2) : CNT_W'(1);
        end
        // Over-issue is clipped so the head never passes the tail.
        pop_n  = (pop_req > count_reg) ? count_reg : pop_req;
        push_n = CNT_W'(bus.inst1_valid_i) + CNT_W'(bus.inst1_valid_i & bus.inst2_valid_i);

        occ_after = {1'b0, count_reg} - {1'b0, pop_n} + {1'b0, push_n};
        push_ok   = (occ_after <= (CNT_W+1)'(DEPTH));

        we1 = push_ok && bus.inst1_valid_i && !bus.flush;
        we2 = we1 && bus.inst2_valid_i;

        head_next  = head_reg + pop_n[PTR_W-1:0];
        tail_next  = push_ok ? (tail_reg + push_n[PTR_W-1:0]) : tail_reg;
        count_next = push_ok ? occ_after[CNT_W-1:0] : (count_reg - pop_n);
        if (bus.flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage holds no reset; validity is tracked purely by count_reg.
    always_ff @(posedge clk) begin
        if (we1) begin
            mem_reg[tail_reg] <= {bus.inst1_addr_i, bus.inst1_i};
        end
        if (we2) begin
            mem_reg[tail_plus1] <= {bus.inst2_addr_i, bus.inst2_i};
        end
    end

    assign rd1 = mem_reg[head_reg];
    assign rd2 = mem_reg[head_plus1];

    assign bus.inst1_valid_o = (count_reg != '0);
    assign bus.inst2_valid_o = (count_reg >= CNT_W'(2));
    assign bus.inst1_o       = bus.inst1_valid_o ? rd1[31:0]  : 32'd0;
    assign bus.inst1_addr_o  = bus.inst1_valid_o ? rd1[63:32] : 32'd0;
    assign bus.inst2_o       = bus.inst2_valid_o ? rd2[31:0]  : 32'd0;
    assign bus.inst2_addr_o  = bus.inst2_valid_o ? rd2[63:32] : 32'd0;
    assign bus.count_o       = count_reg;
    assign bus.full_o        = (count_reg > CNT_W'(DEPTH - 2));
endmodule
